beam_weight_mult: RTL and testbench

Per-channel complex beamforming weight stage. It sits directly upstream of the channel adder, one instance per receive channel (00, 01, 20, 21). Each instance multiplies every complex sample of an AXI-Stream beat by a complex weight, then rounds and saturates the result back to sample width. Weights are frozen for the duration of a packet, so a mid-packet weight update never splits a packet between two beams.

---
 rtl/bf_pkg.sv | 31 +++
 rtl/cmult_round_sat.sv | 77 +++++++
 rtl/beam_weight_mult.sv | 142 ++++++++++++++
 tb/tb_beam_weight_mult.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared widths, rounding/saturation helpers and FSM states for the
// beamforming weight stage.
package bf_pkg;

  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_NLANES       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Half-LSB of the Q1.(ww-1) product scaling, added before the shift.
  function automatic int round_const(input int ww);
    return 1 << (ww - 2);
  endfunction

  function automatic int sat_max(input int sw);
    return (1 << (sw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int sw);
    return -(1 << (sw - 1));
  endfunction

  localparam int ROUND_CONST = round_const(DEF_WEIGHT_WIDTH);
  localparam int SAT_MAX     = sat_max(DEF_SAMPLE_WIDTH);
  localparam int SAT_MIN     = sat_min(DEF_SAMPLE_WIDTH);

endpackage

// File: rtl/cmult_round_sat.sv
// One complex lane: products (S2), then add/sub, round half-up and
// saturate into the output register (S3). Both stages advance on enable.
module cmult_round_sat
  import bf_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic signed [SAMPLE_WIDTH-1:0] i_in,
  input  logic signed [SAMPLE_WIDTH-1:0] q_in,
  input  logic signed [WEIGHT_WIDTH-1:0] wr,
  input  logic signed [WEIGHT_WIDTH-1:0] wi,
  output logic        [SAMPLE_WIDTH-1:0] i_out,
  output logic        [SAMPLE_WIDTH-1:0] q_out,
  output logic        [1:0]              clip
);

  localparam int PW = SAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int FW = PW + 1;
  localparam logic signed [FW-1:0] RND = FW'(round_const(WEIGHT_WIDTH));
  localparam logic signed [FW-1:0] HI  = FW'(sat_max(SAMPLE_WIDTH));
  localparam logic signed [FW-1:0] LO  = FW'(sat_min(SAMPLE_WIDTH));

  logic signed [PW-1:0] p_ir, p_qi, p_iw, p_qr;
  logic signed [FW-1:0] re_full, im_full, re_sh, im_sh;
  logic [SAMPLE_WIDTH-1:0] re_sat, im_sat;
  logic re_clip, im_clip;

  // Clamp a rounded value to sample range; returns {clipped, value}.
  function automatic logic [SAMPLE_WIDTH:0] saturate(input logic signed [FW-1:0] v);
    if (v > HI)      return {1'b1, HI[SAMPLE_WIDTH-1:0]};
    else if (v < LO) return {1'b1, LO[SAMPLE_WIDTH-1:0]};
    else             return {1'b0, v[SAMPLE_WIDTH-1:0]};
  endfunction

  // S2: the four real partial products at full precision.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p_ir <= '0;
      p_qi <= '0;
      p_iw <= '0;
      p_qr <= '0;
    end else if (enable) begin
      p_ir <= i_in * wr;
      p_qi <= q_in * wi;
      p_iw <= i_in * wi;
      p_qr <= q_in * wr;
    end
  end

  // Combine products one bit wider than a product, round, then clamp.
  always_comb begin
    re_full = $signed({p_ir[PW-1], p_ir}) - $signed({p_qi[PW-1], p_qi});
    im_full = $signed({p_iw[PW-1], p_iw}) + $signed({p_qr[PW-1], p_qr});
    re_sh   = (re_full + RND) >>> (WEIGHT_WIDTH - 1);
    im_sh   = (im_full + RND) >>> (WEIGHT_WIDTH - 1);
    {re_clip, re_sat} = saturate(re_sh);
    {im_clip, im_sat} = saturate(im_sh);
  end

  // S3: output register with per-component clip flags (bit0 = I, bit1 = Q).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      i_out <= '0;
      q_out <= '0;
      clip  <= '0;
    end else if (enable) begin
      i_out <= re_sat;
      q_out <= im_sat;
      clip  <= {im_clip, re_clip};
    end
  end

endmodule

// File: rtl/beam_weight_mult.sv
// Per-channel complex beamforming weight stage. Weights follow the ports
// between packets and are frozen from the first beat of a packet to its
// tlast beat; samples are weighted through a three-stage stallable pipe.
module beam_weight_mult
  import bf_pkg::*;
#(
  parameter int SDATA_WIDTH  = 128,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WEIGHT_WIDTH-1:0] w_real,
  input  logic [WEIGHT_WIDTH-1:0] w_imag,
  input  logic [SDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [SDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    in_packet,
  output logic [15:0]             sat_count
);

  localparam int NLANES = SDATA_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int CW     = $clog2(2 * NLANES + 1);

  state_t state, state_next;
  logic enable, accept, weight_load;
  logic signed [WEIGHT_WIDTH-1:0] wr_act, wi_act, wr_use, wi_use;
  logic signed [WEIGHT_WIDTH-1:0] s1_wr, s1_wi;
  logic [SDATA_WIDTH-1:0] s1_data;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic [1:0] lane_clip [NLANES];
  logic [CW-1:0] clip_total;
  logic [16:0] sat_sum;

  assign enable        = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = enable & resetn;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: open a packet on a non-last beat, close it on tlast.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !s_axis_tlast) state_next = PKT;
      PKT:     if (accept && s_axis_tlast)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: weights track the ports only outside a packet.
  always_comb begin
    in_packet   = (state == PKT);
    weight_load = (state == IDLE);
  end

  // Active weights follow the ports in IDLE and hold through a packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_act <= '0;
      wi_act <= '0;
    end else if (weight_load) begin
      wr_act <= w_real;
      wi_act <= w_imag;
    end
  end

  // A beat taken in IDLE must see this cycle's port weights, not last cycle's.
  assign wr_use = weight_load ? w_real : wr_act;
  assign wi_use = weight_load ? w_imag : wi_act;

  // S1 capture plus the valid/tlast pipe that shadows S2 and S3.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_data       <= '0;
      s1_wr         <= '0;
      s1_wi         <= '0;
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (enable) begin
      s1_data       <= s_axis_tdata;
      s1_wr         <= wr_use;
      s1_wi         <= wi_use;
      s1_valid      <= s_axis_tvalid;
      s1_last       <= s_axis_tlast;
      s2_valid      <= s1_valid;
      s2_last       <= s1_last;
      m_axis_tvalid <= s2_valid;
      m_axis_tlast  <= s2_last;
    end
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    cmult_round_sat #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_lane (
      .clock  (clock),
      .resetn (resetn),
      .enable (enable),
      .i_in   (s1_data[2*SAMPLE_WIDTH*gi +: SAMPLE_WIDTH]),
      .q_in   (s1_data[2*SAMPLE_WIDTH*gi + SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .wr     (s1_wr),
      .wi     (s1_wi),
      .i_out  (m_axis_tdata[2*SAMPLE_WIDTH*gi +: SAMPLE_WIDTH]),
      .q_out  (m_axis_tdata[2*SAMPLE_WIDTH*gi + SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .clip   (lane_clip[gi])
    );
  end

  // Number of clipped components in the beat currently on the output.
  always_comb begin
    clip_total = '0;
    for (int k = 0; k < NLANES; k++) begin
      clip_total = clip_total + CW'(lane_clip[k][0]) + CW'(lane_clip[k][1]);
    end
    sat_sum = {1'b0, sat_count} + 17'(clip_total);
  end

  // Saturating clip counter, advanced once per delivered beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sat_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

endmodule

// File: tb/tb_beam_weight_mult.sv
// Scoreboard bench for beam_weight_mult: expected beats are modelled and
// queued on input acceptance, then popped and compared on output handshake.
module tb_beam_weight_mult;

  localparam int DW = 128;
  localparam int NL = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    w_real = '0;
  logic [7:0]    w_imag = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          in_packet;
  logic [15:0]   sat_count;

  beam_weight_mult dut (
    .clock         (clock),
    .resetn        (resetn),
    .w_real        (w_real),
    .w_imag        (w_imag),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .in_packet     (in_packet),
    .sat_count     (sat_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    int            clips;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            exp_sat = 0;
  int            beat_no = 0;
  bit            chk_lat = 1'b1;
  bit            bp_en = 1'b0;
  bit            verbose = 1'b1;
  bit            tb_in_pkt = 1'b0;
  int            pkt_wr = 0;
  int            pkt_wi = 0;
  bit            stalled = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_last;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference arithmetic for Q1.7 weights on 16-bit samples.
  function automatic void model(input logic [DW-1:0] d, input int wr, input int wi,
                                output logic [DW-1:0] o, output int clips);
    o = '0;
    clips = 0;
    for (int k = 0; k < NL; k++) begin
      longint i, q, re, im;
      i  = longint'($signed(d[32*k +: 16]));
      q  = longint'($signed(d[32*k+16 +: 16]));
      re = (i * wr - q * wi + 64) >>> 7;
      im = (i * wi + q * wr + 64) >>> 7;
      if (re > 32767)       begin re = 32767;  clips++; end
      else if (re < -32768) begin re = -32768; clips++; end
      if (im > 32767)       begin im = 32767;  clips++; end
      else if (im < -32768) begin im = -32768; clips++; end
      o[32*k +: 16]    = re[15:0];
      o[32*k+16 +: 16] = im[15:0];
    end
  endfunction

  function automatic logic [DW-1:0] mk4(input int i0, input int q0, input int i1, input int q1,
                                        input int i2, input int q2, input int i3, input int q3);
    logic [DW-1:0] d;
    d = {16'(q3), 16'(i3), 16'(q2), 16'(i2), 16'(q1), 16'(i1), 16'(q0), 16'(i0)};
    return d;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: queue accepted beats, check delivered beats and stall hold.
  always @(negedge clock) begin
    if (resetn) begin
      if (stalled) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, held_d);
        check("hold_last", m_axis_tlast, held_last);
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_t e;
        if (!tb_in_pkt) begin
          pkt_wr = int'($signed(w_real));
          pkt_wi = int'($signed(w_imag));
        end
        model(s_axis_tdata, pkt_wr, pkt_wi, e.d, e.clips);
        e.last = s_axis_tlast;
        e.cyc  = cyc;
        sb.push_back(e);
        tb_in_pkt = !s_axis_tlast;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          beat_no++;
          if (verbose)
            $display("beat %0d: out=%h last=%0d expected=%h", beat_no, m_axis_tdata, m_axis_tlast, e.d);
          check("out_data", m_axis_tdata, e.d);
          check("out_last", m_axis_tlast, e.last);
          if (chk_lat) check("latency", DW'(cyc - e.cyc), DW'(3));
          exp_sat = (exp_sat + e.clips > 65535) ? 65535 : exp_sat + e.clips;
        end
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      held_d    = m_axis_tdata;
      held_last = m_axis_tlast;
    end else begin
      stalled = 1'b0;
    end
  end

  // Downstream ready: random 30% low when backpressure is enabled.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clock);
    while (!s_axis_tready && n < 1000) begin
      n++;
      @(negedge clock);
    end
    if (!s_axis_tready) check("send_ready", s_axis_tready, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    check("drain_empty", DW'(sb.size()), DW'(0));
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a beat offered to prove nothing is accepted.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk4(1, 2, 3, 4, 5, 6, 7, 8);
    repeat (3) @(posedge clock);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_in_packet", in_packet, 0);
    check("rst_sat_count", sat_count, 0);
    s_axis_tvalid = 1'b0;
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Half-scale gain, quarter-turn and rounding, single-beat packets.
    w_real = 8'd64; w_imag = 8'd0;
    send(mk4(1000, -200, 3, -3, -3, 3, 12345, -777), 1'b1);
    check("single_beat_idle", in_packet, 0);
    w_real = 8'd0; w_imag = 8'd64;
    send(mk4(100, 40, -1, 1, 32767, -32768, 255, -256), 1'b1);
    idle();
    w_real = 8'd64; w_imag = 8'd0;
    send(mk4(3, -3, -3, 3, 1, -1, 0, 5), 1'b1);
    idle();
    drain();

    // Saturation on every lane.
    w_real = 8'h80; w_imag = 8'd0;
    send(mk4(-32768, 0, -32768, 0, -32768, 0, -32768, 0), 1'b1);
    idle();
    drain();
    check("sat_count_one", sat_count, DW'(exp_sat));
    check("sat_count_is_4", sat_count, 4);

    // Long saturating run to pin the counter.
    verbose = 1'b0;
    for (int n = 0; n < 20000; n++)
      send(mk4(-32768, 0, -32768, 0, -32768, 0, -32768, 0), 1'b1);
    idle();
    drain();
    check("sat_count_stick", sat_count, 16'hFFFF);
    check("sat_count_model", sat_count, DW'(exp_sat));
    verbose = 1'b1;

    // Weight freeze across a 4-beat packet, new weights on the next packet.
    w_real = 8'd64; w_imag = 8'd0;
    send(mk4(1000, 500, -2000, 300, 40, -40, 7, 9), 1'b0);
    check("in_packet_open", in_packet, 1);
    w_real = 8'd32; w_imag = -8'sd10;
    send(mk4(1200, -600, 800, 900, -50, 60, 11, -13), 1'b0);
    send(mk4(-1000, 250, 4000, -4000, 2, 3, 100, 200), 1'b0);
    w_real = -8'sd50; w_imag = 8'd20;
    send(mk4(3000, 2000, -1500, 700, 33, -44, 555, 666), 1'b1);
    check("in_packet_closed", in_packet, 0);
    send(mk4(1000, 500, -2000, 300, 40, -40, 7, 9), 1'b1);
    idle();
    drain();

    // Random backpressure with continuous random input.
    verbose = 1'b0;
    chk_lat = 1'b0;
    bp_en   = 1'b1;
    for (int n = 0; n < 400; n++) begin
      w_real = 8'($urandom_range(0, 255));
      w_imag = 8'($urandom_range(0, 255));
      send({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
    end
    idle();
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_lat = 1'b1;
    verbose = 1'b1;
    check("bp_sat_count", sat_count, DW'(exp_sat));

    // Reset in the middle of a 5-beat packet.
    w_real = 8'd64; w_imag = 8'd0;
    send(mk4(10, 20, 30, 40, 50, 60, 70, 80), 1'b0);
    send(mk4(11, 21, 31, 41, 51, 61, 71, 81), 1'b0);
    s_axis_tvalid = 1'b0;
    resetn = 1'b0;
    sb.delete();
    tb_in_pkt = 1'b0;
    exp_sat = 0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_in_packet", in_packet, 0);
    check("midrst_tready", s_axis_tready, 0);
    check("midrst_sat_count", sat_count, 0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    w_real = 8'd100; w_imag = -8'sd20;
    send(mk4(1000, -1000, 250, 125, -3, 7, 9000, -9000), 1'b0);
    check("post_rst_open", in_packet, 1);
    w_real = 8'd1; w_imag = 8'd1;
    send(mk4(500, 400, -300, 200, 1, 1, -9000, 9000), 1'b1);
    idle();
    drain();
    check("post_rst_closed", in_packet, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
